// File: rtl/median_window.sv
// Windowed median filter: collects N samples and extracts the exact median by
// repeated max-removal scans. MEDIAN_SIGNED_EN selects two's-complement compares.
module median_window #(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic             DRDY,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             ERR,
  output logic [1:0]       dbg_state
);

  if (N < 3 || N > 15 || (N % 2) == 0) begin : g_bad_n
    $error("median_window: N must be odd and within 3..15");
  end

  localparam int IW = $clog2(N + 1);
  localparam int K  = (N - 1) / 2;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] KP   = IW'(K);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  // Handshake: a sample moves on every rising edge where DSI && DRDY are both high.
  // DSI while DRDY is low drops the sample and sets the sticky ERR flag.

  state_t           state;
  logic [WIDTH-1:0] r [N];
  logic [N-1:0]     alive;
  logic [IW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    pass;
  logic [WIDTH-1:0] max_val;
  logic [IW-1:0]    max_idx;
  logic             have;
  logic             fin;

  logic             have_eff;
  logic             take;
  logic [IW-1:0]    clr_idx;

  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MEDIAN_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  assign DRDY      = (state != SCAN);
  assign dbg_state = state;

  // The first live entry of each pass seeds the running max; strict > keeps the lowest index on ties.
  always_comb begin
    have_eff = have && (idx != '0);
    take     = alive[idx] && (!have_eff || gt(r[idx], max_val));
    clr_idx  = take ? idx : max_idx;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      pass    <= '0;
      alive   <= '1;
      max_val <= '0;
      max_idx <= '0;
      have    <= 1'b0;
      fin     <= 1'b0;
      DO      <= '0;
      DSO     <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DSO <= 1'b0;
      if (DSI && !DRDY) ERR <= 1'b1;
      case (state)
        IDLE: begin
          if (DSI) begin
            r[0]  <= DI;
            cnt   <= IW'(1);
            state <= LOAD;
          end
        end
        LOAD: begin
          if (DSI) begin
            r[cnt] <= DI;
            if (cnt == LAST) begin
              state <= SCAN;
              idx   <= '0;
              pass  <= '0;
              have  <= 1'b0;
              fin   <= 1'b0;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end
        SCAN: begin
          if (fin) begin
            // The final max settled on the previous edge; publish it.
            DO    <= max_val;
            DSO   <= 1'b1;
            fin   <= 1'b0;
            alive <= '1;
            cnt   <= '0;
            state <= DONE;
          end else begin
            if (take) begin
              max_val <= r[idx];
              max_idx <= idx;
            end
            have <= have_eff || alive[idx];
            if (idx == LAST) begin
              idx <= '0;
              if (pass == KP) begin
                fin <= 1'b1;
              end else begin
                alive[clr_idx] <= 1'b0;
                pass           <= pass + IW'(1);
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DONE: begin
          alive <= '1;
          if (DSI) begin
            r[0]  <= DI;
            cnt   <= IW'(1);
            state <= LOAD;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
